// File: rtl/arty_rst_pkg.sv
// Shared types for the Arty board reset/boot sequencer.
// Also holds the helper that sizes the shared cycle counters.
package arty_rst_pkg;

    typedef enum logic [2:0] {
        HOLD,
        PERIPH,
        CORE,
        RUN,
        ASSERT
    } rst_state_e;

    typedef enum logic [1:0] {
        CAUSE_POR = 2'b00,
        CAUSE_BTN = 2'b01,
        CAUSE_SW  = 2'b10
    } rst_cause_e;

    // One spare bit above the largest terminal count, so counters never wrap.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/arty_btn_debounce.sv
// Board button path: two-flop synchronizer followed by a persistence filter.
// The filtered level only follows the pad once it has differed for DEBOUNCE_CYCLES edges.
module arty_btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 17
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic stable_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            // Accept the new level once it has persisted; the counter restarts from zero.
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/arty_rst_seq.sv
// Arty PULPino reset/boot sequencer: ordered release of peripheral reset,
// core reset and fetch enable after power-on/lock, button or software reset.
module arty_rst_seq
    import arty_rst_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter int          RST_HOLD_CYCLES = 64,
    parameter int          STAGE_CYCLES    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_rst_ni,
    input  logic       sw_rst_req_i,
    output logic       periph_rst_no,
    output logic       core_rst_no,
    output logic       fetch_enable_o,
    output logic [1:0] rst_cause_o,
    output logic       seq_busy_o
);

    localparam int CNT_W = cnt_width(int'(DEBOUNCE_CYCLES), RST_HOLD_CYCLES, STAGE_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_CYCLES - 1);

    logic             btn_stable;
    rst_state_e       state_q;
    rst_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    rst_cause_e       cause_q;
    rst_cause_e       cause_d;
    logic             periph_q;
    logic             periph_d;
    logic             core_q;
    logic             core_d;
    logic             fetch_q;
    logic             fetch_d;
    logic             busy_q;
    logic             busy_d;

    arty_btn_debounce #(
        .DEBOUNCE_CYCLES(int'(DEBOUNCE_CYCLES)),
        .CNT_W          (CNT_W)
    ) u_btn (
        .clk     (clk),
        .rst     (rst),
        .raw_i   (btn_rst_ni),
        .stable_o(btn_stable)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= HOLD;
            cnt_q    <= '0;
            cause_q  <= CAUSE_POR;
            periph_q <= 1'b0;
            core_q   <= 1'b0;
            fetch_q  <= 1'b0;
            busy_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cause_q  <= cause_d;
            periph_q <= periph_d;
            core_q   <= core_d;
            fetch_q  <= fetch_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        // The button outranks everything, including a coincident software request.
        if (state_q != ASSERT && !btn_stable) begin
            state_d = ASSERT;
            cnt_d   = '0;
            cause_d = CAUSE_BTN;
        end else begin
            case (state_q)
                HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = PERIPH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                PERIPH: begin
                    if (cnt_q == STAGE_LAST) begin
                        state_d = CORE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                CORE: begin
                    if (cnt_q == STAGE_LAST) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                RUN: begin
                    cnt_d = '0;
                    if (sw_rst_req_i) begin
                        state_d = HOLD;
                        cause_d = CAUSE_SW;
                    end
                end
                ASSERT: begin
                    cnt_d = '0;
                    if (btn_stable) state_d = HOLD;
                end
                default: begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the settled state and registered, so they never glitch.
    always_comb begin
        periph_d = (state_q == PERIPH) || (state_q == CORE) || (state_q == RUN);
        core_d   = (state_q == CORE) || (state_q == RUN);
        fetch_d  = (state_q == RUN);
        busy_d   = (state_q != RUN);
    end

    assign periph_rst_no  = periph_q;
    assign core_rst_no    = core_q;
    assign fetch_enable_o = fetch_q;
    assign rst_cause_o    = cause_q;
    assign seq_busy_o     = busy_q;

endmodule

// File: tb/tb_arty_rst_seq.sv
// Bench for arty_rst_seq: directed scenarios against fixed release timings, then
// randomized button/software/reset traffic against a timestamp-based reference model.
module tb_arty_rst_seq;
    import arty_rst_pkg::*;

    localparam int D = 4;
    localparam int H = 8;
    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn;
    logic       sw;
    logic       periph_no;
    logic       core_no;
    logic       fetch_en;
    logic       busy;
    logic [1:0] cause;
    logic [5:0] obs;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: edge index, start edge of the current release sequence,
    // filter run-length and the outputs expected after the latest edge.
    int         t = 0;
    int         m_E = 0;
    int         m_run = 0;
    logic       m_s1 = 1'b1;
    logic       m_s2 = 1'b1;
    logic       m_stable = 1'b1;
    logic       m_in_assert = 1'b0;
    logic [1:0] m_cause = 2'b00;
    logic [5:0] m_obs = 6'b000100;

    arty_rst_seq #(
        .DEBOUNCE_CYCLES(16'(D)),
        .RST_HOLD_CYCLES(H),
        .STAGE_CYCLES   (S)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_rst_ni    (btn),
        .sw_rst_req_i  (sw),
        .periph_rst_no (periph_no),
        .core_rst_no   (core_no),
        .fetch_enable_o(fetch_en),
        .rst_cause_o   (cause),
        .seq_busy_o    (busy)
    );

    always #5 clk = ~clk;

    assign obs = {periph_no, core_no, fetch_en, busy, cause};

    function automatic logic [5:0] pack(input logic p, input logic c, input logic f,
                                        input logic [1:0] ca);
        return {p, c, f, ~f, ca};
    endfunction

    function automatic void model_edge();
        int   k;
        logic running;
        logic p;
        logic c;
        logic f;
        if (rst) begin
            m_s1        = 1'b1;
            m_s2        = 1'b1;
            m_stable    = 1'b1;
            m_run       = 0;
            m_in_assert = 1'b0;
            m_cause     = 2'b00;
            m_E         = t;
            m_obs       = pack(1'b0, 1'b0, 1'b0, 2'b00);
        end else begin
            k       = t - 1 - m_E;
            p       = !m_in_assert && (k >= H);
            c       = !m_in_assert && (k >= H + S);
            f       = !m_in_assert && (k >= H + 2 * S);
            running = !m_in_assert && (k >= H + 2 * S);
            if (!m_in_assert && !m_stable) begin
                m_in_assert = 1'b1;
                m_cause     = 2'b01;
            end else if (m_in_assert && m_stable) begin
                m_in_assert = 1'b0;
                m_E         = t;
            end else if (running && sw) begin
                m_E     = t;
                m_cause = 2'b10;
            end
            m_obs = pack(p, c, f, m_cause);
            if (m_s2 != m_stable) begin
                m_run++;
                if (m_run == D) begin
                    m_stable = m_s2;
                    m_run    = 0;
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = btn;
        end
        t++;
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        btn = 1'b1;
        sw  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (obs !== pack(1'b0, 1'b0, 1'b0, CAUSE_POR)) begin
                n_errors++;
                $display("FAIL reset i=%0d got=%b want=%b", i, obs, pack(1'b0, 1'b0, 1'b0, CAUSE_POR));
            end
        end
    endtask

    task automatic test_power_on();
        logic [5:0] want;
        rst = 1'b0;
        for (int c = 0; c <= 19; c++) begin
            step();
            want = pack(c >= H, c >= H + S, c >= H + 2 * S, CAUSE_POR);
            n_checks++;
            if (obs !== want) begin
                n_errors++;
                $display("FAIL power_on edge=%0d got=%b want=%b", c, obs, want);
            end
        end
    endtask

    task automatic test_btn_glitch();
        logic [5:0] want;
        want = pack(1'b1, 1'b1, 1'b1, CAUSE_POR);
        btn  = 1'b0;
        step();
        step();
        step();
        btn = 1'b1;
        for (int j = 0; j < 12; j++) begin
            step();
            n_checks++;
            if (obs !== want) begin
                n_errors++;
                $display("FAIL btn_glitch j=%0d got=%b want=%b", j, obs, want);
            end
        end
    endtask

    task automatic test_btn_press();
        logic [5:0] want;
        btn = 1'b0;
        for (int j = 0; j < 10; j++) begin
            step();
            want = pack(j < 7, j < 7, j < 7, (j >= 6) ? CAUSE_BTN : CAUSE_POR);
            n_checks++;
            if (obs !== want) begin
                n_errors++;
                $display("FAIL btn_press j=%0d got=%b want=%b", j, obs, want);
            end
        end
        btn = 1'b1;
        for (int j = 0; j < 25; j++) begin
            step();
            want = pack(j >= 15, j >= 19, j >= 23, CAUSE_BTN);
            n_checks++;
            if (obs !== want) begin
                n_errors++;
                $display("FAIL btn_release j=%0d got=%b want=%b", j, obs, want);
            end
        end
    endtask

    task automatic test_sw_reset();
        logic [5:0] want;
        sw = 1'b1;
        step();
        sw = 1'b0;
        n_checks++;
        if (obs !== pack(1'b1, 1'b1, 1'b1, CAUSE_SW)) begin
            n_errors++;
            $display("FAIL sw_edge got=%b want=%b", obs, pack(1'b1, 1'b1, 1'b1, CAUSE_SW));
        end
        for (int j = 1; j <= 17; j++) begin
            step();
            want = pack(j >= H + 1, j >= H + S + 1, j >= H + 2 * S + 1, CAUSE_SW);
            n_checks++;
            if (obs !== want) begin
                n_errors++;
                $display("FAIL sw_reset j=%0d got=%b want=%b", j, obs, want);
            end
        end
    endtask

    task automatic test_sw_in_core();
        logic [5:0] want;
        sw = 1'b1;
        step();
        sw = 1'b0;
        for (int j = 1; j <= 18; j++) begin
            sw = (j == 13);
            step();
            sw = 1'b0;
            want = pack(j >= H + 1, j >= H + S + 1, j >= H + 2 * S + 1, CAUSE_SW);
            n_checks++;
            if (obs !== want) begin
                n_errors++;
                $display("FAIL sw_in_core j=%0d got=%b want=%b", j, obs, want);
            end
        end
    endtask

    task automatic test_btn_sw_same();
        logic [5:0] want;
        btn = 1'b0;
        for (int j = 0; j < 10; j++) begin
            sw = (j == 6);
            step();
            sw   = 1'b0;
            want = pack(j < 7, j < 7, j < 7, (j >= 6) ? CAUSE_BTN : CAUSE_SW);
            n_checks++;
            if (obs !== want) begin
                n_errors++;
                $display("FAIL btn_sw_same j=%0d got=%b want=%b", j, obs, want);
            end
        end
        btn = 1'b1;
        for (int j = 0; j < 24; j++) begin
            step();
            want = pack(j >= 15, j >= 19, j >= 23, CAUSE_BTN);
            n_checks++;
            if (obs !== want) begin
                n_errors++;
                $display("FAIL btn_sw_release j=%0d got=%b want=%b", j, obs, want);
            end
        end
    endtask

    task automatic test_btn_in_hold();
        logic [5:0] want;
        sw  = 1'b1;
        btn = 1'b0;
        for (int j = 0; j < 10; j++) begin
            step();
            sw = 1'b0;
            if (j == 0) want = pack(1'b1, 1'b1, 1'b1, CAUSE_SW);
            else        want = pack(1'b0, 1'b0, 1'b0, (j >= 6) ? CAUSE_BTN : CAUSE_SW);
            n_checks++;
            if (obs !== want) begin
                n_errors++;
                $display("FAIL btn_in_hold j=%0d got=%b want=%b", j, obs, want);
            end
        end
        btn = 1'b1;
        for (int j = 0; j < 24; j++) begin
            step();
            want = pack(j >= 15, j >= 19, j >= 23, CAUSE_BTN);
            n_checks++;
            if (obs !== want) begin
                n_errors++;
                $display("FAIL hold_release j=%0d got=%b want=%b", j, obs, want);
            end
        end
    endtask

    task automatic test_rst_mid();
        logic [5:0] want;
        sw = 1'b1;
        step();
        sw = 1'b0;
        for (int j = 1; j <= 9; j++) step();
        rst = 1'b1;
        step();
        n_checks++;
        if (obs !== pack(1'b0, 1'b0, 1'b0, CAUSE_POR)) begin
            n_errors++;
            $display("FAIL rst_mid got=%b want=%b", obs, pack(1'b0, 1'b0, 1'b0, CAUSE_POR));
        end
        rst = 1'b0;
        for (int c = 0; c <= 17; c++) begin
            step();
            want = pack(c >= H, c >= H + S, c >= H + 2 * S, CAUSE_POR);
            n_checks++;
            if (obs !== want) begin
                n_errors++;
                $display("FAIL rst_restart edge=%0d got=%b want=%b", c, obs, want);
            end
        end
    endtask

    task automatic test_random();
        int hold_left;
        hold_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold_left == 0) begin
                btn = ~btn;
                if (btn) hold_left = int'($urandom_range(5, 60));
                else     hold_left = int'($urandom_range(1, 14));
            end
            hold_left--;
            sw  = ($urandom_range(0, 15) == 0);
            rst = ($urandom_range(0, 499) == 0);
            step();
            n_checks++;
            if (obs !== m_obs) begin
                n_errors++;
                $display("FAIL random i=%0d got=%b want=%b", i, obs, m_obs);
            end
        end
        rst = 1'b0;
        sw  = 1'b0;
        btn = 1'b1;
    endtask

    initial begin
        test_reset();
        test_power_on();
        test_btn_glitch();
        test_btn_press();
        test_sw_reset();
        test_sw_in_core();
        test_btn_sw_same();
        test_btn_in_hold();
        test_rst_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/arty_rst_seq.md
# arty_rst_seq

Board-level reset and boot sequencer for the Arty PULPino top. It turns the raw active-low board reset button and a software reset request into an ordered release: peripheral reset, then core reset, then `fetch_enable`. It sits between the clock generator / board pins and `pulpino_top`. It replaces the direct `locked & ck_rst` reset and the constant `fetch_enable_i = 1`.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 16'd50000: cycles the synchronized button must differ from its filtered state before the change is accepted; ≥1.
- `RST_HOLD_CYCLES`, 64: cycles all resets stay asserted after entering HOLD; ≥1.
- `STAGE_CYCLES`, 16: gap from peripheral release to core release, and from core release to fetch enable; ≥1.

Ports:
- `clk` in 1: system clock (MMCM output). One clock domain; reset is synchronous and active-high.
- `rst` in 1: synchronous active-high reset; the top drives it from `~locked`.
- `btn_rst_ni` in 1: raw board reset button, active-low, asynchronous to `clk`.
- `sw_rst_req_i` in 1: single-cycle software reset request (from a GPIO bit).
- `periph_rst_no` out 1: peripheral/SoC reset, active-low.
- `core_rst_no` out 1: core reset, active-low; connects to `pulpino_top.rst_n`.
- `fetch_enable_o` out 1: connects to `pulpino_top.fetch_enable_i`.
- `rst_cause_o` out 2: cause of the last reset. 00 = power-on/lock, 01 = button, 10 = software.
- `seq_busy_o` out 1: high whenever the state is not RUN.

## Operation
- **Button path:** 2-flop synchronizer, both flops reset to 1, feeding a debounce filter.
  - The filter holds `btn_stable`, reset value 1 (released), and a counter.
  - The counter increments while sync ≠ stable and clears when they are equal.
  - When the counter reaches `DEBOUNCE_CYCLES-1` with sync still ≠ stable, `btn_stable` takes the sync value and the counter clears.
- **FSM states:** HOLD, PERIPH, CORE, RUN, ASSERT. Reset state is HOLD with its counter at 0.
- **HOLD:** all three outputs are in their asserted state (resets low, `fetch_enable_o` low). The counter runs to `RST_HOLD_CYCLES-1`, then the FSM goes to PERIPH.
- **PERIPH:** `periph_rst_no`=1. After `STAGE_CYCLES` the FSM goes to CORE.
- **CORE:** `core_rst_no`=1. After `STAGE_CYCLES` the FSM goes to RUN.
- **RUN:** `fetch_enable_o`=1.
- **Button press (`btn_stable`=0) in any state except ASSERT:**
  - Next state is ASSERT and all outputs are asserted.
  - `rst_cause_o` is set to 01.
  - A press during HOLD, PERIPH or CORE restarts the sequence.
- **ASSERT:** outputs stay asserted until `btn_stable`=1, then the FSM goes to HOLD with the counter cleared.
- **`sw_rst_req_i`:**
  - In RUN: next state is HOLD, outputs are asserted and `rst_cause_o` is set to 10.
  - In any other state it is ignored.
- **Simultaneous button press and `sw_rst_req_i`:** the button wins (ASSERT, cause 01).
- **`rst` high:** state HOLD, counters 0, synchronizer 1, `btn_stable` 1, `rst_cause_o` 00, all outputs asserted, at the next edge. This holds mid-sequence too.
- All outputs are registered and glitch-free.

## Timing
- Output values during and after `rst`: `periph_rst_no`=0, `core_rst_no`=0, `fetch_enable_o`=0, `rst_cause_o`=00, `seq_busy_o`=1.
- Release schedule, with cycle 0 = the first edge sampling `rst`=0 and the button released:
  - `periph_rst_no` rises after edge `RST_HOLD_CYCLES`.
  - `core_rst_no` rises `STAGE_CYCLES` edges after that.
  - `fetch_enable_o` and `seq_busy_o`=0 change `STAGE_CYCLES` edges after that.
- Button press latency: from the pad edge to all outputs asserted is `2 + DEBOUNCE_CYCLES + 1` edges.
- Software reset: with `sw_rst_req_i` sampled at edge N in RUN, outputs are asserted after edge N+1. `periph_rst_no` rises after edge N+1+`RST_HOLD_CYCLES`.
- Glitches on the button shorter than `DEBOUNCE_CYCLES` have no effect.

## Structure
- Package `arty_rst_pkg` contains:
  - `rst_state_e` (HOLD, PERIPH, CORE, RUN, ASSERT);
  - `rst_cause_e` (CAUSE_POR=2'b00, CAUSE_BTN=2'b01, CAUSE_SW=2'b10).
- Sub-module `arty_btn_debounce` (clk, rst, raw_i, stable_o) holds the synchronizer and filter.
- Counter width is `$clog2` of the maximum of the three cycle parameters, plus 1. No wrap-around is permitted.

## Test plan
Parameters for all tests: `DEBOUNCE_CYCLES`=4, `RST_HOLD_CYCLES`=8, `STAGE_CYCLES`=4.
1. Deassert `rst`, button held released → `periph_rst_no` rises at edge 8, `core_rst_no` at 12, `fetch_enable_o` at 16, `rst_cause_o`=00.
2. In RUN, 3-cycle button low pulse → no output change. 10-cycle low pulse, then release → outputs asserted at pad+7, cause 01. The release sequence starts after the debounced release.
3. In RUN, 1-cycle `sw_rst_req_i` at N → outputs low at N+1, `periph_rst_no` high at N+9, cause 10. The same pulse during CORE → ignored.
4. Button press and `sw_rst_req_i` debounced in the same cycle → cause 01, state ASSERT.
5. `rst` pulsed during PERIPH → all outputs 0 and cause 00 at the next edge; the full 8/12/16 schedule restarts.
6. Button pressed during HOLD at count 5 → sequence restarts after release; no output rises early.
